// File: rtl/div_clk_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | div_clk_meter                                                            |
// | Measures the period of a divided clock in clk_i cycles, flags lock/timeout|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module div_clk_meter #(
  parameter int CNT_W    = 8,
  parameter int TIMEOUT  = 255,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 0
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             div_clk_i,
  output logic             edge_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic             locked_o,
  output logic             timeout_o
);

  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] c_TIMEOUT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
  localparam logic [MC_W-1:0]  c_LOCK_CNT = MC_W'(LOCK_CNT);
  localparam logic [CNT_W:0]   c_TOL      = (CNT_W + 1)'(TOL);

  typedef enum logic [1:0] {
    ST_SEEK  = 2'd0,
    ST_FIRST = 2'd1,
    ST_TRACK = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_s1, r_s2, r_s3;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_ref;
  logic [MC_W-1:0]  r_mcnt;

  logic             w_ev;
  logic [CNT_W:0]   w_diff;
  logic             w_match;
  logic [MC_W-1:0]  w_mcnt_next;

  assign w_ev = r_s2 & ~r_s3;

  // One extra bit keeps the absolute difference free of wrap-around
  assign w_diff = (r_cnt >= r_ref) ? ({1'b0, r_cnt} - {1'b0, r_ref})
                                   : ({1'b0, r_ref} - {1'b0, r_cnt});
  assign w_match = (w_diff <= c_TOL);
  assign w_mcnt_next = !w_match                  ? '0 :
                       (r_mcnt == c_LOCK_CNT)    ? r_mcnt :
                                                   r_mcnt + MC_W'(1);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state        <= ST_SEEK;
      r_s1           <= 1'b0;
      r_s2           <= 1'b0;
      r_s3           <= 1'b0;
      r_cnt          <= '0;
      r_ref          <= '0;
      r_mcnt         <= '0;
      edge_o         <= 1'b0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      locked_o       <= 1'b0;
      timeout_o      <= 1'b0;
    end else begin
      r_s1           <= div_clk_i;
      r_s2           <= r_s1;
      r_s3           <= r_s2;
      edge_o         <= w_ev;
      period_valid_o <= 1'b0;

      if (w_ev)
        r_cnt <= CNT_W'(1);
      else if (r_cnt != c_CNT_MAX)
        r_cnt <= r_cnt + CNT_W'(1);

      if (w_ev)
        timeout_o <= 1'b0;

      case (r_state)
        ST_SEEK: begin
          if (w_ev)
            r_state <= ST_FIRST;
        end
        ST_FIRST: begin
          if (w_ev) begin
            period_o       <= r_cnt;
            period_valid_o <= 1'b1;
            r_ref          <= r_cnt;
            r_mcnt         <= '0;
            locked_o       <= 1'b0;
            r_state        <= ST_TRACK;
          end else if (r_cnt == c_TIMEOUT) begin
            timeout_o <= 1'b1;
            locked_o  <= 1'b0;
            r_mcnt    <= '0;
            r_state   <= ST_SEEK;
          end
        end
        ST_TRACK: begin
          if (w_ev) begin
            period_o       <= r_cnt;
            period_valid_o <= 1'b1;
            r_ref          <= r_cnt;
            r_mcnt         <= w_mcnt_next;
            locked_o       <= (w_mcnt_next == c_LOCK_CNT);
          end else if (r_cnt == c_TIMEOUT) begin
            timeout_o <= 1'b1;
            locked_o  <= 1'b0;
            r_mcnt    <= '0;
            r_state   <= ST_SEEK;
          end
        end
        default: r_state <= ST_SEEK;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_clk_meter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_div_clk_meter                                                         |
// | Self-checking bench: two meters (TOL=0 and TOL=1) against an event model  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_div_clk_meter;

  localparam int CNT_W    = 8;
  localparam int TIMEOUT  = 255;
  localparam int LOCK_CNT = 4;
  localparam int NSAMP    = 32768;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  logic div_clk_i = 1'b0;

  logic             edge0, pv0, lock0, to0;
  logic [CNT_W-1:0] per0;
  logic             edge1, pv1, lock1, to1;
  logic [CNT_W-1:0] per1;

  div_clk_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .LOCK_CNT(LOCK_CNT), .TOL(0)) dut0 (
    .clk_i(clk_i), .rstn_i(rstn_i), .div_clk_i(div_clk_i),
    .edge_o(edge0), .period_o(per0), .period_valid_o(pv0),
    .locked_o(lock0), .timeout_o(to0)
  );

  div_clk_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .LOCK_CNT(LOCK_CNT), .TOL(1)) dut1 (
    .clk_i(clk_i), .rstn_i(rstn_i), .div_clk_i(div_clk_i),
    .edge_o(edge1), .period_o(per1), .period_valid_o(pv1),
    .locked_o(lock1), .timeout_o(to1)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model: works on posedge indices and elapsed time between edges
  bit samp [NSAMP];
  int m = 0;
  int rst_m = 0;
  int phase = 0;        // 0 no edge, 1 one edge seen, 2 periods flowing
  int last_m = 0;
  int ref_p = 0;
  int streak [2];
  int tol [2] = '{0, 1};
  bit e_edge, e_pv, e_timeout;
  bit e_locked [2];
  int e_period;

  function automatic bit get(int j);
    return (j < rst_m || j < 0) ? 1'b0 : samp[j];
  endfunction

  task automatic model_reset();
    phase = 0; last_m = 0; ref_p = 0;
    e_edge = 0; e_pv = 0; e_timeout = 0; e_period = 0;
    for (int k = 0; k < 2; k++) begin
      streak[k] = 0;
      e_locked[k] = 0;
    end
  endtask

  task automatic model_step();
    bit ev;
    int p, d;
    // A rising edge sampled at posedge j shows on the outputs after posedge j+2
    ev = get(m - 2) && !get(m - 3);
    e_edge = ev;
    e_pv = 0;
    if (ev) begin
      e_timeout = 0;
      if (phase == 0) begin
        phase = 1;
      end else begin
        p = m - last_m;
        e_period = p;
        e_pv = 1;
        for (int k = 0; k < 2; k++) begin
          if (phase == 1) begin
            streak[k] = 0;
          end else begin
            d = (p > ref_p) ? p - ref_p : ref_p - p;
            streak[k] = (d <= tol[k]) ? ((streak[k] + 1 > LOCK_CNT) ? LOCK_CNT : streak[k] + 1) : 0;
          end
          e_locked[k] = (streak[k] == LOCK_CNT);
        end
        ref_p = p;
        phase = 2;
      end
      last_m = m;
    end else if (phase != 0 && (m - last_m) == TIMEOUT) begin
      e_timeout = 1;
      phase = 0;
      for (int k = 0; k < 2; k++) begin
        streak[k] = 0;
        e_locked[k] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0d expected %0d", tag, m, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("d0.edge",    32'(edge0), 32'(e_edge));
    chk("d0.pvalid",  32'(pv0),   32'(e_pv));
    chk("d0.period",  32'(per0),  32'(e_period));
    chk("d0.locked",  32'(lock0), 32'(e_locked[0]));
    chk("d0.timeout", 32'(to0),   32'(e_timeout));
    chk("d1.edge",    32'(edge1), 32'(e_edge));
    chk("d1.pvalid",  32'(pv1),   32'(e_pv));
    chk("d1.period",  32'(per1),  32'(e_period));
    chk("d1.locked",  32'(lock1), 32'(e_locked[1]));
    chk("d1.timeout", 32'(to1),   32'(e_timeout));
  endtask

  task automatic tick(input bit v);
    @(negedge clk_i);
    div_clk_i = v;
    @(posedge clk_i);
    m++;
    samp[m % NSAMP] = v;
    if (!rstn_i) begin
      model_reset();
      rst_m = m + 1;
    end else begin
      model_step();
    end
    #1;
    check_all();
  endtask

  task automatic wave(input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (hi) tick(1'b1);
      repeat (lo) tick(1'b0);
    end
  endtask

  task automatic async_reset(input bit div_at_release);
    @(negedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    chk("rst.d0.locked", 32'(lock0), 32'd0);
    chk("rst.d0.period", 32'(per0),  32'd0);
    chk("rst.d0.pvalid", 32'(pv0),   32'd0);
    chk("rst.d0.edge",   32'(edge0), 32'd0);
    chk("rst.d0.tmo",    32'(to0),   32'd0);
    chk("rst.d1.locked", 32'(lock1), 32'd0);
    repeat (3) tick(div_at_release);
    #2 rstn_i = 1'b1;
  endtask

  initial begin
    int hi, lo;
    model_reset();
    repeat (3) tick(1'b0);
    #2 rstn_i = 1'b1;

    // Constant divide-by-16, then ratio change to /8
    wave(8, 8, 12);
    wave(4, 4, 10);
    // Back to /16, lock, then stop and resume
    wave(8, 8, 8);
    tick(1'b1);
    repeat (300) tick(1'b0);
    wave(8, 8, 4);

    // Timeout boundary: 255 spacing is a valid period, 256 is not
    wave(100, 155, 4);
    wave(100, 156, 3);

    // Alternating 16/17 periods
    for (int i = 0; i < 8; i++) begin
      wave(8, 8, 1);
      wave(8, 9, 1);
    end

    // Reset while locked, released with div_clk_i high
    wave(8, 8, 8);
    repeat (3) tick(1'b1);
    async_reset(1'b1);
    repeat (5) tick(1'b1);
    repeat (11) tick(1'b0);
    wave(8, 8, 7);

    // Random periods and duty cycles, with occasional near-timeout gaps
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        hi = $urandom_range(1, 10);
        lo = $urandom_range(250, 260) - hi;
      end else if ($urandom_range(0, 1) == 0) begin
        hi = $urandom_range(1, 20);
        lo = $urandom_range(1, 20);
      end else begin
        hi = 6;
        lo = $urandom_range(6, 7);
      end
      wave(hi, lo, 1);
    end

    // Random mid-stream reset
    async_reset(1'($urandom_range(0, 1)));
    wave(5, 5, 8);
    repeat (10) tick(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
